shwr_integral_ctrl: RTL and testbench

SHWR_INTEGRAL_CTRL -- requirements
Module: shwr_integral_ctrl

---
 rtl/shwr_integral_ctrl_if.sv | 32 +++
 rtl/shwr_integral_ctrl.sv | 138 +++++++++++++
 tb/tb_shwr_integral_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/shwr_integral_ctrl_if.sv
// Result stream interface for shwr_integral_ctrl.
// One transfer per rising edge where OUT_VALID and OUT_READY are both high.
//   master (controller): drives OUT_VALID, OUT_CHAN, OUT_INTEGRAL, OUT_PEAK, OUT_SAT; samples OUT_READY
//   slave  (consumer)  : drives OUT_READY; samples the rest
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 19
`endif
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif

interface shwr_integral_ctrl_if #(
  parameter int AW = `SHWR_AREA_WIDTH,
  parameter int PW = `ADC_WIDTH
);
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [2:0]    OUT_CHAN;
  logic [AW-1:0] OUT_INTEGRAL;
  logic [PW-1:0] OUT_PEAK;
  logic          OUT_SAT;

  modport master (
    output OUT_VALID, OUT_CHAN, OUT_INTEGRAL, OUT_PEAK, OUT_SAT,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID, OUT_CHAN, OUT_INTEGRAL, OUT_PEAK, OUT_SAT,
    output OUT_READY
  );
endinterface

// File: rtl/shwr_integral_ctrl.sv
// Sequencer for NCH shwr_integral channels: on an accepted trigger it holds
// TRIGGERED high for a WIN_LEN-cycle window plus one capture cycle, snapshots
// every channel's INTEGRAL/PEAK/SATURATED, then streams the snapshot out one
// channel per transfer.
// Ports:
//   CLK120       single clock, rising edge
//   RESET        synchronous, active-high
//   ENABLE       arms acceptance of new triggers
//   TRIG_IN      level-sampled trigger request
//   INTEGRAL_IN  per-channel integral, channel k at [k*AW +: AW]
//   PEAK_IN      per-channel peak, channel k at [k*PW +: PW]
//   SAT_IN       per-channel saturation flag
//   TRIGGERED    common TRIGGERED to all channels
//   HILO         constant per-channel gain selection (HILO_MASK)
//   BUSY         high whenever the sequencer is not idle
//   MISSED       saturating count of rejected trigger cycles
//   out_if       result stream (master side)
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 19
`endif
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif

module shwr_integral_ctrl #(
  parameter int              NCH       = 6,
  parameter logic [15:0]     WIN_LEN   = 16'd2048,
  parameter logic [NCH-1:0]  HILO_MASK = 6'b101010,
  parameter int              AW        = `SHWR_AREA_WIDTH,
  parameter int              PW        = `ADC_WIDTH
) (
  input  logic                CLK120,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic                TRIG_IN,
  input  logic [NCH*AW-1:0]   INTEGRAL_IN,
  input  logic [NCH*PW-1:0]   PEAK_IN,
  input  logic [NCH-1:0]      SAT_IN,
  output logic                TRIGGERED,
  output logic [NCH-1:0]      HILO,
  output logic                BUSY,
  output logic [15:0]         MISSED,
  shwr_integral_ctrl_if.master out_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INTEG,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  localparam logic [2:0] LAST_CHAN = 3'(NCH - 1);

  state_t         state, state_nxt;
  logic [15:0]    cnt;
  logic [2:0]     chan;
  logic [AW-1:0]  sh_int  [NCH];
  logic [PW-1:0]  sh_peak [NCH];
  logic [NCH-1:0] sh_sat;

  logic accept;
  logic xfer;
  logic last_xfer;
  logic out_valid;

  assign HILO      = HILO_MASK;
  assign accept    = (state == S_IDLE) && TRIG_IN && ENABLE;
  assign out_valid = (state == S_DRAIN);
  assign xfer      = out_valid && out_if.OUT_READY;
  assign last_xfer = xfer && (chan == LAST_CHAN);

  always_comb begin
    state_nxt = state;
    TRIGGERED = 1'b0;
    BUSY      = 1'b1;
    unique case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (accept) state_nxt = S_INTEG;
      end
      S_INTEG: begin
        TRIGGERED = 1'b1;
        if (cnt == WIN_LEN - 16'd1) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        TRIGGERED = 1'b1;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_xfer) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      chan   <= '0;
      MISSED <= '0;
      sh_sat <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        sh_int[i]  <= '0;
        sh_peak[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (state == S_INTEG) cnt <= cnt + 16'd1;
      else                  cnt <= '0;

      if (state == S_CAPTURE) begin
        chan   <= '0;
        sh_sat <= SAT_IN;
        for (int unsigned i = 0; i < NCH; i++) begin
          sh_int[i]  <= INTEGRAL_IN[i*AW +: AW];
          sh_peak[i] <= PEAK_IN[i*PW +: PW];
        end
      end else if (xfer) begin
        chan <= last_xfer ? 3'd0 : chan + 3'd1;
      end

      // Any asserted trigger cycle that does not start an event is a miss,
      // including the cycle that closes the drain.
      if (TRIG_IN && !accept && (MISSED != 16'hFFFF))
        MISSED <= MISSED + 16'd1;
    end
  end

  assign out_if.OUT_VALID    = out_valid;
  assign out_if.OUT_CHAN     = chan;
  assign out_if.OUT_INTEGRAL = sh_int[chan];
  assign out_if.OUT_PEAK     = sh_peak[chan];
  assign out_if.OUT_SAT      = sh_sat[chan];

endmodule

// File: tb/tb_shwr_integral_ctrl.sv
module tb_shwr_integral_ctrl;
  localparam int NCH = 6;
  localparam int AW  = 19;
  localparam int PW  = 12;

  logic              CLK120 = 1'b0;
  logic              RESET;
  logic              ENABLE;
  logic              TRIG_IN;
  logic [NCH*AW-1:0] INTEGRAL_IN;
  logic [NCH*PW-1:0] PEAK_IN;
  logic [NCH-1:0]    SAT_IN;
  logic              TRIGGERED;
  logic [NCH-1:0]    HILO;
  logic              BUSY;
  logic [15:0]       MISSED;

  int checks = 0;
  int errors = 0;

  shwr_integral_ctrl_if #(.AW(AW), .PW(PW)) out_if ();

  shwr_integral_ctrl #(
    .NCH(NCH), .WIN_LEN(16'd4), .HILO_MASK(6'b101010), .AW(AW), .PW(PW)
  ) dut (
    .CLK120(CLK120), .RESET(RESET), .ENABLE(ENABLE), .TRIG_IN(TRIG_IN),
    .INTEGRAL_IN(INTEGRAL_IN), .PEAK_IN(PEAK_IN), .SAT_IN(SAT_IN),
    .TRIGGERED(TRIGGERED), .HILO(HILO), .BUSY(BUSY), .MISSED(MISSED),
    .out_if(out_if.master)
  );

  always #5 CLK120 = ~CLK120;

  task automatic tick();
    @(posedge CLK120);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input int base_int);
    for (int k = 0; k < NCH; k++) begin
      INTEGRAL_IN[k*AW +: AW] = AW'(base_int + k);
      PEAK_IN[k*PW +: PW]     = PW'(10 + k);
      SAT_IN[k]               = k[0];
    end
  endtask

  initial begin
    int n;
    RESET = 1'b1; ENABLE = 1'b0; TRIG_IN = 1'b1; out_if.OUT_READY = 1'b0;
    INTEGRAL_IN = '0; PEAK_IN = '0; SAT_IN = '0;
    tick();
    check("hilo_in_reset", 32'(HILO), 32'h2A);
    tick();
    RESET = 1'b0; TRIG_IN = 1'b0;
    check("rst_triggered", 32'(TRIGGERED), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_missed", 32'(MISSED), 0);
    check("rst_valid", 32'(out_if.OUT_VALID), 0);
    check("rst_chan", 32'(out_if.OUT_CHAN), 0);
    check("rst_integral", 32'(out_if.OUT_INTEGRAL), 0);

    // Basic event, WIN_LEN=4: TRIGGERED for 5 cycles then drain
    set_inputs(100);
    ENABLE = 1'b1; TRIG_IN = 1'b1;
    tick();
    TRIG_IN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("win_trig_%0d", i), 32'(TRIGGERED), 1);
      check($sformatf("win_busy_%0d", i), 32'(BUSY), 1);
      check($sformatf("win_valid_%0d", i), 32'(out_if.OUT_VALID), 0);
      tick();
    end
    check("drain_trig", 32'(TRIGGERED), 0);
    check("drain_valid", 32'(out_if.OUT_VALID), 1);
    check("hilo_drain", 32'(HILO), 32'h2A);

    // Stall with live inputs changing: outputs must hold
    INTEGRAL_IN = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall_chan_%0d", i), 32'(out_if.OUT_CHAN), 0);
      check($sformatf("stall_int_%0d", i), 32'(out_if.OUT_INTEGRAL), 100);
    end

    out_if.OUT_READY = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("xfer_valid_%0d", k), 32'(out_if.OUT_VALID), 1);
      check($sformatf("xfer_chan_%0d", k), 32'(out_if.OUT_CHAN), 32'(k));
      check($sformatf("xfer_int_%0d", k), 32'(out_if.OUT_INTEGRAL), 32'(100 + k));
      check($sformatf("xfer_peak_%0d", k), 32'(out_if.OUT_PEAK), 32'(10 + k));
      check($sformatf("xfer_sat_%0d", k), 32'(out_if.OUT_SAT), 32'(k % 2));
      tick();
    end
    out_if.OUT_READY = 1'b0;
    check("post_drain_valid", 32'(out_if.OUT_VALID), 0);
    check("post_drain_busy", 32'(BUSY), 0);
    check("missed_still_0", 32'(MISSED), 0);

    // Missed triggers: 2 cycles disabled in IDLE, 3 cycles during INTEG
    set_inputs(100);
    ENABLE = 1'b0; TRIG_IN = 1'b1;
    tick(); tick();
    check("disabled_busy", 32'(BUSY), 0);
    check("missed_2", 32'(MISSED), 2);
    ENABLE = 1'b1;
    tick();
    check("accept_busy", 32'(BUSY), 1);
    check("accept_not_missed", 32'(MISSED), 2);
    ENABLE = 1'b0;          // must not abort the event
    tick(); tick(); tick();
    TRIG_IN = 1'b0;
    check("missed_5", 32'(MISSED), 5);
    n = 0;
    while (!out_if.OUT_VALID && n < 20) begin tick(); n++; end
    check("ev2_valid_reached", 32'(out_if.OUT_VALID), 1);
    out_if.OUT_READY = 1'b1;
    n = 0;
    while (out_if.OUT_VALID && n < 20) begin tick(); n++; end
    out_if.OUT_READY = 1'b0;
    check("ev2_xfer_count", 32'(n), NCH);
    check("ev2_idle", 32'(BUSY), 0);
    check("missed_after_ev2", 32'(MISSED), 5);

    // Reset mid-window at counter=2, with TRIG_IN high during reset
    ENABLE = 1'b1; TRIG_IN = 1'b1;
    tick();
    TRIG_IN = 1'b0;
    tick(); tick();
    RESET = 1'b1; TRIG_IN = 1'b1;
    check("hilo_reset_mid", 32'(HILO), 32'h2A);
    tick();
    RESET = 1'b0; TRIG_IN = 1'b0;
    check("midrst_trig", 32'(TRIGGERED), 0);
    check("midrst_busy", 32'(BUSY), 0);
    check("midrst_missed", 32'(MISSED), 0);
    check("midrst_integral", 32'(out_if.OUT_INTEGRAL), 0);
    check("midrst_peak", 32'(out_if.OUT_PEAK), 0);
    TRIG_IN = 1'b1;
    tick();
    TRIG_IN = 1'b0;
    n = 0;
    while (TRIGGERED && n < 20) begin tick(); n++; end
    check("fresh_window_len", 32'(n), 5);
    check("fresh_valid", 32'(out_if.OUT_VALID), 1);
    out_if.OUT_READY = 1'b1;
    n = 0;
    while (out_if.OUT_VALID && n < 20) begin tick(); n++; end
    out_if.OUT_READY = 1'b0;
    check("fresh_idle", 32'(BUSY), 0);

    // MISSED saturation
    ENABLE = 1'b0; TRIG_IN = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    TRIG_IN = 1'b0;
    check("missed_sat", 32'(MISSED), 32'hFFFF);
    check("hilo_idle", 32'(HILO), 32'h2A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
